// File: rtl/usb_pkg.sv
// Shared USB definitions for the EP0 control path: handshake codes, token PIDs,
// EP0 stage encodings and a small length helper.
package usb_pkg;

    localparam logic [1:0] hs_ack   = 2'b00;
    localparam logic [1:0] hs_none  = 2'b01;
    localparam logic [1:0] hs_nak   = 2'b10;
    localparam logic [1:0] hs_stall = 2'b11;

    localparam logic [1:0] pid_out   = 2'b00;
    localparam logic [1:0] pid_in    = 2'b01;
    localparam logic [1:0] pid_setup = 2'b10;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StSetupWait = 3'd1,
        StDataIn    = 3'd2,
        StDataOut   = 3'd3,
        StStatusIn  = 3'd4,
        StStatusOut = 3'd5,
        StStall     = 3'd6
    } ep0_stage_e;

    function automatic logic [15:0] min16(input logic [15:0] a, input logic [15:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/usb_ep0_chunker.sv
// EP0 data-stage bookkeeping: remaining/offset counters, the MAX_PKT chunk and
// the pending zero-length-packet flag.
module usb_ep0_chunker
    import usb_pkg::*;
#(
    parameter int unsigned MAX_PKT = 8,
    parameter int unsigned OFS_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [15:0]      load_total,
    input  logic [15:0]      load_wlength,
    input  logic             load_force_zlp,
    input  logic             ack,
    input  logic             sub_en,
    input  logic [6:0]       sub_len,
    output logic [6:0]       chunk,
    output logic [OFS_W-1:0] offset,
    output logic [15:0]      remaining_next,
    output logic             zlp_next
);

    localparam logic [15:0] MaxPkt16 = 16'(MAX_PKT);
    localparam logic [15:0] PktMask  = MaxPkt16 - 16'd1;

    logic [15:0]      remaining_q, remaining_d;
    logic [OFS_W-1:0] offset_q, offset_d;
    logic             zlp_q, zlp_d;
    logic [15:0]      chunk16;
    logic [15:0]      sub16;

    always_comb begin
        chunk16 = (remaining_q > MaxPkt16) ? MaxPkt16 : remaining_q;
        sub16   = {9'd0, sub_len};
    end

    always_comb begin
        remaining_d = remaining_q;
        offset_d    = offset_q;
        zlp_d       = zlp_q;
        if (load) begin
            remaining_d = load_total;
            offset_d    = '0;
            // A short reply that ends exactly on a packet boundary needs a ZLP to terminate it.
            zlp_d = load_force_zlp ||
                    ((load_total != 16'd0) && (load_total < load_wlength) &&
                     ((load_total & PktMask) == 16'd0));
        end else if (ack) begin
            remaining_d = remaining_q - chunk16;
            offset_d    = offset_q + OFS_W'(chunk16);
            if (chunk16 == 16'd0) begin
                zlp_d = 1'b0;
            end
        end else if (sub_en) begin
            remaining_d = (remaining_q > sub16) ? (remaining_q - sub16) : 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining_q <= '0;
            offset_q    <= '0;
            zlp_q       <= 1'b0;
        end else begin
            remaining_q <= remaining_d;
            offset_q    <= offset_d;
            zlp_q       <= zlp_d;
        end
    end

    assign chunk          = chunk16[6:0];
    assign offset         = offset_q;
    assign remaining_next = remaining_d;
    assign zlp_next       = zlp_d;

endmodule

// File: rtl/usb_ep0_sequencer.sv
// EP0 control-transfer stage sequencer (SETUP -> DATA -> STATUS) with registered outputs.
// Define USB_EP0_STALL_EN to STALL unsupported requests; otherwise they get an empty data stage.
module usb_ep0_sequencer
    import usb_pkg::*;
#(
    parameter int unsigned MAX_PKT = 8,
    parameter int unsigned OFS_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tok_valid,
    input  logic [1:0]       tok_pid,
    input  logic             rx_data_ok,
    input  logic             rx_toggle,
    input  logic [6:0]       rx_len,
    input  logic             host_ack,
    input  logic             tx_busy,
    input  logic             setup_ready,
    input  logic             setup_dir_in,
    input  logic [15:0]      setup_wlength,
    input  logic [7:0]       resp_len,
    input  logic             resp_unsupported,
    output logic             tx_start,
    output logic [6:0]       tx_len,
    output logic [OFS_W-1:0] tx_offset,
    output logic             tx_data1,
    output logic             hs_valid,
    output logic [1:0]       hs_code,
    output logic             xfer_finished,
    output logic [2:0]       stage
);

    localparam logic [6:0] MaxPkt7 = 7'(MAX_PKT);

    ep0_stage_e       state_q, state_d;
    logic             toggle_q, toggle_d;
    logic             sent_q, sent_d;
    logic             tx_start_q, tx_start_d;
    logic [6:0]       tx_len_q, tx_len_d;
    logic [OFS_W-1:0] tx_offset_q, tx_offset_d;
    logic             tx_data1_q, tx_data1_d;
    logic             hs_valid_q, hs_valid_d;
    logic [1:0]       hs_code_q, hs_code_d;
    logic             xfer_finished_q, xfer_finished_d;

    logic             tok_in, tok_out, tok_setup, tok_io;
    logic             ck_load, ck_ack, ck_sub, ck_force_zlp, ck_zlp_next;
    logic [15:0]      ck_total, ck_rem_next;
    logic [6:0]       ck_chunk;
    logic [OFS_W-1:0] ck_offset;

    always_comb begin
        tok_in    = tok_valid && (tok_pid == pid_in);
        tok_out   = tok_valid && (tok_pid == pid_out);
        tok_setup = tok_valid && (tok_pid == pid_setup);
        tok_io    = tok_in || tok_out;
    end

    always_comb begin
        ck_total     = min16(setup_wlength, {8'h00, resp_len});
        ck_force_zlp = 1'b0;
`ifndef USB_EP0_STALL_EN
        // Unsupported request: answer with an empty data stage instead of stalling.
        if (resp_unsupported) begin
            ck_total     = 16'd0;
            ck_force_zlp = 1'b1;
        end
`endif
    end

    usb_ep0_chunker #(
        .MAX_PKT(MAX_PKT),
        .OFS_W  (OFS_W)
    ) u_chunker (
        .clk           (clk),
        .rst           (rst),
        .load          (ck_load),
        .load_total    (ck_total),
        .load_wlength  (setup_wlength),
        .load_force_zlp(ck_force_zlp),
        .ack           (ck_ack),
        .sub_en        (ck_sub),
        .sub_len       (rx_len),
        .chunk         (ck_chunk),
        .offset        (ck_offset),
        .remaining_next(ck_rem_next),
        .zlp_next      (ck_zlp_next)
    );

    always_comb begin
        state_d         = state_q;
        toggle_d        = toggle_q;
        sent_d          = sent_q;
        tx_start_d      = 1'b0;
        tx_len_d        = tx_len_q;
        tx_offset_d     = tx_offset_q;
        tx_data1_d      = tx_data1_q;
        hs_valid_d      = 1'b0;
        hs_code_d       = hs_none;
        xfer_finished_d = 1'b0;
        ck_load         = 1'b0;
        ck_ack          = 1'b0;
        ck_sub          = 1'b0;

        if (tok_setup) begin
            state_d = StSetupWait;
            sent_d  = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (tok_io) begin
                        hs_valid_d = 1'b1;
                        hs_code_d  = hs_nak;
                    end
                end
                StSetupWait: begin
                    if (rx_data_ok && !rx_toggle) begin
                        hs_valid_d = 1'b1;
                        hs_code_d  = hs_ack;
                    end
                    if (setup_ready) begin
                        ck_load  = 1'b1;
                        toggle_d = 1'b1;
                        sent_d   = 1'b0;
                        if (setup_wlength == 16'd0) begin
                            state_d = StStatusIn;
                        end else if (setup_dir_in) begin
                            state_d = StDataIn;
                        end else begin
                            state_d = StDataOut;
                        end
`ifdef USB_EP0_STALL_EN
                        if (resp_unsupported) begin
                            state_d = StStall;
                        end
`endif
                    end else if (tok_io) begin
                        hs_valid_d = 1'b1;
                        hs_code_d  = hs_nak;
                    end
                end
                StDataIn: begin
                    if (tok_out) begin
                        state_d = StStatusOut;
                        sent_d  = 1'b0;
                    end else begin
                        if (host_ack && sent_q) begin
                            ck_ack   = 1'b1;
                            toggle_d = ~toggle_q;
                            sent_d   = 1'b0;
                        end
                        if (tok_in) begin
                            if (tx_busy) begin
                                hs_valid_d = 1'b1;
                                hs_code_d  = hs_nak;
                            end else begin
                                // Until acked, every IN re-sends the same chunk and toggle.
                                tx_start_d  = 1'b1;
                                tx_len_d    = ck_chunk;
                                tx_offset_d = ck_offset;
                                tx_data1_d  = toggle_q;
                                sent_d      = 1'b1;
                            end
                        end
                        if ((ck_rem_next == 16'd0) && !ck_zlp_next) begin
                            state_d = StStatusOut;
                            sent_d  = 1'b0;
                        end
                    end
                end
                StDataOut: begin
                    if (rx_data_ok) begin
                        hs_valid_d = 1'b1;
                        hs_code_d  = hs_ack;
                        if (rx_toggle == toggle_q) begin
                            ck_sub   = 1'b1;
                            toggle_d = ~toggle_q;
                            if ((rx_len < MaxPkt7) || (ck_rem_next == 16'd0)) begin
                                state_d = StStatusIn;
                            end
                        end
                    end else if (tok_in) begin
                        state_d = StStatusIn;
                    end
                end
                StStatusIn: begin
                    if (host_ack && sent_q) begin
                        xfer_finished_d = 1'b1;
                        state_d         = StIdle;
                        sent_d          = 1'b0;
                    end else if (tok_in) begin
                        if (tx_busy) begin
                            hs_valid_d = 1'b1;
                            hs_code_d  = hs_nak;
                        end else begin
                            tx_start_d  = 1'b1;
                            tx_len_d    = 7'd0;
                            tx_offset_d = '0;
                            tx_data1_d  = 1'b1;
                            sent_d      = 1'b1;
                        end
                    end
                end
                StStatusOut: begin
                    if (rx_data_ok && (rx_len == 7'd0)) begin
                        hs_valid_d      = 1'b1;
                        hs_code_d       = hs_ack;
                        xfer_finished_d = 1'b1;
                        state_d         = StIdle;
                    end else if (tok_in) begin
                        hs_valid_d = 1'b1;
                        hs_code_d  = hs_nak;
                    end
                end
`ifdef USB_EP0_STALL_EN
                StStall: begin
                    if (tok_io) begin
                        hs_valid_d = 1'b1;
                        hs_code_d  = hs_stall;
                    end
                end
`endif
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            toggle_q        <= 1'b0;
            sent_q          <= 1'b0;
            tx_start_q      <= 1'b0;
            tx_len_q        <= '0;
            tx_offset_q     <= '0;
            tx_data1_q      <= 1'b0;
            hs_valid_q      <= 1'b0;
            hs_code_q       <= hs_none;
            xfer_finished_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            toggle_q        <= toggle_d;
            sent_q          <= sent_d;
            tx_start_q      <= tx_start_d;
            tx_len_q        <= tx_len_d;
            tx_offset_q     <= tx_offset_d;
            tx_data1_q      <= tx_data1_d;
            hs_valid_q      <= hs_valid_d;
            hs_code_q       <= hs_code_d;
            xfer_finished_q <= xfer_finished_d;
        end
    end

    assign tx_start      = tx_start_q;
    assign tx_len        = tx_len_q;
    assign tx_offset     = tx_offset_q;
    assign tx_data1      = tx_data1_q;
    assign hs_valid      = hs_valid_q;
    assign hs_code       = hs_code_q;
    assign xfer_finished = xfer_finished_q;
    assign stage         = state_q;

endmodule

// File: tb/tb_usb_ep0_sequencer.sv
// Scoreboard bench for usb_ep0_sequencer: a host-side driver runs randomized control
// transfers, a transfer-level model queues expected events, and a monitor checks them.
module tb_usb_ep0_sequencer;
    import usb_pkg::*;

    localparam int MaxPkt  = 8;
    localparam int OfsW    = 8;
    localparam int KindTx  = 0;
    localparam int KindHs  = 1;
    localparam int KindFin = 2;

    typedef struct {
        int kind;
        int cyc;
        int a;
        int b;
        int c;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            tok_valid = 1'b0;
    logic [1:0]      tok_pid = 2'b00;
    logic            rx_data_ok = 1'b0;
    logic            rx_toggle = 1'b0;
    logic [6:0]      rx_len = '0;
    logic            host_ack = 1'b0;
    logic            tx_busy = 1'b0;
    logic            setup_ready = 1'b0;
    logic            setup_dir_in = 1'b0;
    logic [15:0]     setup_wlength = '0;
    logic [7:0]      resp_len = '0;
    logic            resp_unsupported = 1'b0;
    logic            tx_start;
    logic [6:0]      tx_len;
    logic [OfsW-1:0] tx_offset;
    logic            tx_data1;
    logic            hs_valid;
    logic [1:0]      hs_code;
    logic            xfer_finished;
    logic [2:0]      stage;

    int   ncyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   force_nak = 1'b0;
    exp_t sb[$];

    usb_ep0_sequencer #(
        .MAX_PKT(MaxPkt),
        .OFS_W  (OfsW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .tok_valid       (tok_valid),
        .tok_pid         (tok_pid),
        .rx_data_ok      (rx_data_ok),
        .rx_toggle       (rx_toggle),
        .rx_len          (rx_len),
        .host_ack        (host_ack),
        .tx_busy         (tx_busy),
        .setup_ready     (setup_ready),
        .setup_dir_in    (setup_dir_in),
        .setup_wlength   (setup_wlength),
        .resp_len        (resp_len),
        .resp_unsupported(resp_unsupported),
        .tx_start        (tx_start),
        .tx_len          (tx_len),
        .tx_offset       (tx_offset),
        .tx_data1        (tx_data1),
        .hs_valid        (hs_valid),
        .hs_code         (hs_code),
        .xfer_finished   (xfer_finished),
        .stage           (stage)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ncyc <= ncyc + 1;

    // Every response is due on the cycle after the input that triggers it.
    function automatic void expect_evt(int kind, int a, int b, int c);
        exp_t e;
        e.kind = kind;
        e.cyc  = ncyc + 1;
        e.a    = a;
        e.b    = b;
        e.c    = c;
        sb.push_back(e);
    endfunction

    function automatic void check_evt(int kind, int a, int b, int c);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event: got kind=%0d a=%0d b=%0d c=%0d at cycle %0d, expected none",
                     kind, a, b, c, ncyc);
            return;
        end
        e = sb.pop_front();
        if (e.kind != kind || e.cyc != ncyc || e.a != a || (e.b >= 0 && e.b != b) || e.c != c) begin
            miscompares++;
            $display("FAIL event: got kind=%0d cyc=%0d a=%0d b=%0d c=%0d, expected kind=%0d cyc=%0d a=%0d b=%0d c=%0d",
                     kind, ncyc, a, b, c, e.kind, e.cyc, e.a, e.b, e.c);
        end
    endfunction

    function automatic void check_val(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (tx_start)      check_evt(KindTx, int'(tx_len), int'(tx_offset), int'(tx_data1));
        if (hs_valid)      check_evt(KindHs, int'(hs_code), 0, 0);
        if (xfer_finished) check_evt(KindFin, 0, 0, 0);
    end

    function automatic logic [1:0] rand_io();
        return ($urandom_range(0, 1) != 0) ? pid_in : pid_out;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_tok(input logic [1:0] pid);
        tok_pid   = pid;
        tok_valid = 1'b1;
        tick();
        tok_valid = 1'b0;
    endtask

    task automatic send_rx(input logic tog, input int len);
        rx_toggle  = tog;
        rx_len     = 7'(len);
        rx_data_ok = 1'b1;
        tick();
        rx_data_ok = 1'b0;
    endtask

    task automatic send_ack();
        host_ack = 1'b1;
        tick();
        host_ack = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_stage"}, int'(stage), 0);
        check_val({tag, "_hs_code"}, int'(hs_code), int'(hs_none));
        check_val({tag, "_hs_valid"}, int'(hs_valid), 0);
        check_val({tag, "_tx_start"}, int'(tx_start), 0);
        check_val({tag, "_tx_len"}, int'(tx_len), 0);
        check_val({tag, "_tx_offset"}, int'(tx_offset), 0);
        check_val({tag, "_tx_data1"}, int'(tx_data1), 0);
        check_val({tag, "_xfer_finished"}, int'(xfer_finished), 0);
    endtask

    task automatic status_in_stage();
        if ($urandom_range(0, 1) != 0) begin
            expect_evt(KindHs, int'(hs_nak), 0, 0);
            tx_busy = 1'b1;
            send_tok(pid_in);
            tx_busy = 1'b0;
            idle(1);
        end
        expect_evt(KindTx, 0, -1, 1);
        send_tok(pid_in);
        idle(1);
        expect_evt(KindFin, 0, 0, 0);
        send_ack();
        idle(1);
    endtask

    task automatic status_out_stage();
        if ($urandom_range(0, 2) == 0) begin
            expect_evt(KindHs, int'(hs_nak), 0, 0);
            send_tok(pid_in);
            idle(1);
        end
        send_tok(pid_out);
        idle(1);
        expect_evt(KindHs, int'(hs_ack), 0, 0);
        expect_evt(KindFin, 0, 0, 0);
        send_rx(1'b1, 0);
        idle(1);
    endtask

    // One host-side control transfer; done=0 when it was left stalled or aborted.
    task automatic run_xfer(input int wl, input int rl, input bit dir_in, input bit unsup,
                            input bit may_abort, output bit done);
        int tot, off, rem, len;
        bit tog, zlp;
        int pk[$];
        done = 1'b0;
        send_tok(pid_setup);
        idle(1);
        if (force_nak || $urandom_range(0, 2) == 0) begin
            expect_evt(KindHs, int'(hs_nak), 0, 0);
            send_tok(rand_io());
            idle(1);
            force_nak = 1'b0;
        end
        expect_evt(KindHs, int'(hs_ack), 0, 0);
        send_rx(1'b0, 8);
        idle(1);
        setup_wlength    = 16'(wl);
        resp_len         = 8'(rl);
        setup_dir_in     = dir_in;
        resp_unsupported = unsup;
        setup_ready      = 1'b1;
        tick();
        setup_ready      = 1'b0;
        resp_unsupported = 1'b0;
        idle(1);
`ifdef USB_EP0_STALL_EN
        if (unsup) begin
            repeat (3) begin
                expect_evt(KindHs, int'(hs_stall), 0, 0);
                send_tok(rand_io());
                idle(1);
            end
            return;
        end
`endif
        tot = (wl < rl) ? wl : rl;
        zlp = (tot != 0) && (tot < wl) && (tot % MaxPkt == 0);
`ifndef USB_EP0_STALL_EN
        if (unsup) begin
            tot = 0;
            zlp = 1'b1;
        end
`endif
        if (wl == 0) begin
            status_in_stage();
        end else if (dir_in) begin
            for (off = 0; off < tot; off += MaxPkt) pk.push_back((tot - off > MaxPkt) ? MaxPkt : tot - off);
            if (zlp) pk.push_back(0);
            off = 0;
            tog = 1'b1;
            for (int i = 0; i < pk.size(); i++) begin
                if (may_abort && i == 1 && $urandom_range(0, 3) == 0) begin
                    force_nak = 1'b1;
                    return;
                end
                if ($urandom_range(0, 5) == 0) begin
                    send_tok(pid_out);
                    idle(1);
                    break;
                end
                if ($urandom_range(0, 2) == 0) begin
                    expect_evt(KindHs, int'(hs_nak), 0, 0);
                    tx_busy = 1'b1;
                    send_tok(pid_in);
                    tx_busy = 1'b0;
                    idle(1);
                end
                expect_evt(KindTx, pk[i], off, int'(tog));
                send_tok(pid_in);
                idle(1);
                if ($urandom_range(0, 2) == 0) begin
                    expect_evt(KindTx, pk[i], off, int'(tog));
                    send_tok(pid_in);
                    idle(1);
                end
                send_ack();
                idle(1);
                off += pk[i];
                tog = !tog;
            end
            status_out_stage();
        end else begin
            rem = tot;
            tog = 1'b1;
            for (int n = 0; n < 64; n++) begin
                if ($urandom_range(0, 5) == 0) begin
                    send_tok(pid_in);
                    idle(1);
                    break;
                end
                if ($urandom_range(0, 3) == 0) begin
                    expect_evt(KindHs, int'(hs_ack), 0, 0);
                    send_rx(!tog, MaxPkt);
                    idle(1);
                end
                len = ($urandom_range(0, 1) != 0) ? MaxPkt : int'($urandom_range(0, MaxPkt - 1));
                expect_evt(KindHs, int'(hs_ack), 0, 0);
                send_rx(tog, len);
                idle(1);
                rem = (rem > len) ? rem - len : 0;
                tog = !tog;
                if (len < MaxPkt || rem == 0) break;
            end
            status_in_stage();
        end
        done = 1'b1;
    endtask

    task automatic xfer_and_probe(input int wl, input int rl, input bit dir_in, input bit unsup,
                                  input bit may_abort);
        bit d;
        run_xfer(wl, rl, dir_in, unsup, may_abort, d);
        if (d) begin
            expect_evt(KindHs, int'(hs_nak), 0, 0);
            send_tok(rand_io());
            idle(1);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wl, rl;
        idle(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        idle(2);

        xfer_and_probe(64, 18, 1'b1, 1'b0, 1'b0);
        xfer_and_probe(16, 16, 1'b1, 1'b0, 1'b0);
        xfer_and_probe(64, 16, 1'b1, 1'b0, 1'b0);
        xfer_and_probe(0, 0, 1'b0, 1'b0, 1'b0);
        xfer_and_probe(64, 40, 1'b1, 1'b1, 1'b0);
        xfer_and_probe(12, 0, 1'b0, 1'b1, 1'b0);
        xfer_and_probe(20, 0, 1'b0, 1'b0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 3))
                0:       wl = 0;
                1:       wl = MaxPkt * int'($urandom_range(1, 8));
                2:       wl = int'($urandom_range(1, 80));
                default: wl = int'($urandom_range(100, 300));
            endcase
            rl = ($urandom_range(0, 1) != 0) ? MaxPkt * int'($urandom_range(0, 6))
                                             : int'($urandom_range(0, 120));
            xfer_and_probe(wl, rl, $urandom_range(0, 1) != 0, $urandom_range(0, 7) == 0, 1'b1);
        end

        // Reset in the middle of a data stage must abandon it without any pulse.
        send_tok(pid_setup);
        idle(1);
        expect_evt(KindHs, int'(hs_ack), 0, 0);
        send_rx(1'b0, 8);
        idle(1);
        setup_wlength = 16'd64;
        resp_len      = 8'd18;
        setup_dir_in  = 1'b1;
        setup_ready   = 1'b1;
        tick();
        setup_ready   = 1'b0;
        idle(1);
        expect_evt(KindTx, MaxPkt, 0, 1);
        send_tok(pid_in);
        idle(1);
        rst      = 1'b1;
        host_ack = 1'b1;
        tick();
        host_ack = 1'b0;
        tick();
        check_reset_outputs("midreset");
        rst = 1'b0;
        idle(2);
        expect_evt(KindHs, int'(hs_nak), 0, 0);
        send_tok(pid_in);
        idle(3);

        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL missing_events: got %0d events outstanding, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/usb_ep0_sequencer.md
Name: usb_ep0_sequencer

Overview:
- Stage sequencer for control endpoint 0. Tracks SETUP → DATA → STATUS for every control transfer.
- Splits the responder's staged reply into MAX_PKT chunks and manages DATA0/DATA1 toggles and ZLPs.
- Picks the handshake for each token and pulses xfer_finished. That pulse drives the setup responder's control_transaction_finished.
- Sits between the token/packet layer and the setup responder / send queue.

Parameters:
- MAX_PKT, 8: EP0 max packet size in bytes, legal values 8/16/32/64.
- OFS_W, 8: width of the byte offset into the responder's staged reply.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- tok_valid  in  1  one-cycle pulse; token addressed to this device, EP0
- tok_pid  in  2  00 OUT, 01 IN, 10 SETUP, 11 reserved (ignored)
- rx_data_ok  in  1  pulse; DATA packet received with good CRC
- rx_toggle  in  1  PID of the received DATA packet (0 = DATA0)
- rx_len  in  7  payload length of the received DATA packet
- host_ack  in  1  pulse; host ACKed our last DATA packet
- tx_busy  in  1  send path not ready
- setup_ready  in  1  level; responder has decoded the 8 setup bytes
- setup_dir_in  in  1  bmRequestType[7]
- setup_wlength  in  16  wLength
- resp_len  in  8  bytes the responder has staged
- resp_unsupported  in  1  request not recognised
- tx_start  out  1  pulse; send one DATA packet
- tx_len  out  7  payload length, 0..MAX_PKT
- tx_offset  out  OFS_W  offset of the first byte in the staged reply
- tx_data1  out  1  1 = DATA1
- hs_valid  out  1  pulse; handshake decision is valid
- hs_code  out  2  00 ACK, 01 none, 10 NAK, 11 STALL
- xfer_finished  out  1  pulse at end of the status stage
- stage  out  3  current state, for debug

Behaviour:
- Reset (synchronous, active-high rst, clock clk):
  - state IDLE.
  - All outputs 0, except hs_code = 01 (none).
  - Internal counters and toggle cleared.
  - Reset mid-transfer abandons it silently: no pulses.
- Timing:
  - All outputs are registered. A response appears the cycle after its triggering input.
  - Pulses last exactly one cycle.
- Transfer length:
  - total = min(setup_wlength, {8'h0, resp_len}), 16-bit.
  - remaining is a 16-bit down-counter.
  - chunk = min(remaining, MAX_PKT).
- ZLP: zlp_pend is set on entry to DATA_IN when all hold:
  - total != 0,
  - total < setup_wlength,
  - total % MAX_PKT == 0.
- States:
  - IDLE: IN/OUT token → NAK.
  - SETUP_WAIT:
    - rx_data_ok with rx_toggle = 0 → ACK.
    - IN/OUT token before setup_ready → NAK.
    - When setup_ready: resp_unsupported → STALL; setup_wlength == 0 → STATUS_IN; setup_dir_in → DATA_IN (toggle = 1); otherwise → DATA_OUT (toggle = 1).
  - DATA_IN:
    - IN token with tx_busy = 0 → tx_start with len = chunk (0 if only the ZLP remains), offset, tx_data1 = toggle.
    - IN token with tx_busy = 1 → NAK.
    - host_ack → offset += len, remaining -= len, toggle flips; if len was 0, clear zlp_pend.
    - When remaining == 0 and zlp_pend == 0 → STATUS_OUT.
    - No ACK before the next IN → resend the same chunk with the same toggle.
    - OUT token → early status: go to STATUS_OUT.
  - DATA_OUT:
    - rx_data_ok with rx_toggle == toggle → ACK, remaining -= rx_len (saturating at 0), toggle flips. Then if rx_len < MAX_PKT or remaining == 0 → STATUS_IN.
    - Toggle mismatch → ACK, no advance (duplicate packet).
    - IN token → STATUS_IN.
  - STATUS_IN:
    - IN token → tx_start, len 0, DATA1.
    - host_ack → xfer_finished, IDLE.
    - tx_busy → NAK.
  - STATUS_OUT:
    - rx_data_ok with rx_len == 0 → ACK, xfer_finished, IDLE.
    - IN token → NAK.
  - STALL: every IN/OUT token → STALL. Leaves only on SETUP.
- SETUP token in any state:
  - Abort the current transfer and go to SETUP_WAIT.
  - No xfer_finished.
  - Takes priority over same-cycle host_ack or rx_data_ok.

Optional Feature:
- Macro USB_EP0_STALL_EN.
- Defined: resp_unsupported → STALL state as above.
- Undefined: resp_unsupported is ignored. The request proceeds with total = 0, giving a zero-length data stage and then a normal status stage. The STALL state is not built.

Decomposition:
- Shared package usb_pkg:
  - handshake codes hs_ack = 2'b00, hs_none = 2'b01, hs_nak = 2'b10, hs_stall = 2'b11;
  - token PID codes;
  - EP0 stage encodings.
- One sub-module, usb_ep0_chunker: computes chunk, the remaining/offset update and zlp_pend from total, MAX_PKT and host_ack.

Test Plan:
- GET_DESCRIPTOR, wLength 64, resp_len 18, MAX_PKT 8 → tx (len,offset,data1) = (8,0,1), (8,8,0), (2,16,1); then OUT ZLP → ACK, xfer_finished.
- wLength 16, resp_len 16 → two 8-byte packets, no ZLP. wLength 64, resp_len 16 → 8, 8, then 0-byte DATA1.
- SET_ADDRESS, wLength 0 → STATUS_IN; IN → len 0 DATA1; host_ack → xfer_finished next cycle.
- Drop host_ack after the first chunk, send IN again → same offset 0, DATA1. tx_busy = 1 on IN → hs NAK.
- SETUP token mid DATA_IN → SETUP_WAIT, no xfer_finished; next IN before setup_ready → NAK.
- resp_unsupported with USB_EP0_STALL_EN → every IN/OUT gets STALL until SETUP; without the macro → ZLP data stage, then normal status.
